signal_checker: RTL and testbench

SIGNAL_CHECKER -- requirements
Module: signal_checker

---
 rtl/signal_pkg.sv | 14 +
 rtl/sig_history.sv | 20 ++
 rtl/signal_checker.sv | 90 +++++++++
 tb/tb_signal_checker.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/signal_pkg.sv
// signal_pkg: shared pattern, limits and state type for the serial pattern checker
package signal_pkg;
    localparam logic [5:0] PATTERN    = 6'b100111;
    localparam int         PAT_LEN    = 6;
    localparam int         MISS_LIMIT = 3;
    localparam int         ERR_MAX    = 255;

    typedef enum logic [1:0] {HUNT, CONFIRM, LOCK} state_t;

    // P[0] is transmitted first and sits in the MSB of PATTERN
    function automatic logic pat_bit(input logic [2:0] idx);
        return PATTERN[3'(PAT_LEN - 1) - idx];
    endfunction
endpackage

// File: rtl/sig_history.sv
// sig_history: serial bit history with pattern detection including the current bit
module sig_history
    import signal_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic match
);
    logic [5:0] hist;

    assign match = {hist[4:0], din} == PATTERN;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            hist <= '0;
        else if (en)
            hist <= {hist[4:0], din};
endmodule

// File: rtl/signal_checker.sv
// signal_checker: hunts for the repeating pattern, confirms one period, then counts bit errors
module signal_checker
    import signal_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       din,
    input  logic       clr,
    output logic       locked,
    output logic       err_pulse,
    output logic [7:0] err_cnt,
    output logic       frame_pulse,
    output logic [2:0] phase
);
    state_t     state, state_n;
    logic [2:0] phase_n, phase_inc, good, good_n;
    logic [1:0] miss, miss_n;
    logic [7:0] cnt_n;
    logic       match, hit, last, err_n, frame_n;

    sig_history u_hist (.clk, .rst, .en, .din, .match);

    assign last      = phase == 3'(PAT_LEN - 1);
    assign phase_inc = last ? 3'd0 : phase + 3'd1;
    assign hit       = din == pat_bit(phase);
    assign cnt_n     = clr ? 8'd0 : (err_n && err_cnt != 8'(ERR_MAX)) ? err_cnt + 8'd1 : err_cnt;

    always_comb begin
        state_n = state;
        phase_n = phase;
        good_n  = good;
        miss_n  = miss;
        err_n   = 1'b0;
        frame_n = 1'b0;
        if (en)
            case (state)
                HUNT:
                    if (match) begin
                        state_n = CONFIRM;
                        phase_n = '0;
                        good_n  = '0;
                    end
                CONFIRM:
                    if (hit) begin
                        phase_n = phase_inc;
                        good_n  = good + 3'd1;
                        if (good == 3'(PAT_LEN - 1)) begin
                            state_n = LOCK;
                            miss_n  = '0;
                        end
                    end else
                        state_n = HUNT;
                LOCK: begin
                    // phase free-runs in lock so a single bad bit cannot slip alignment
                    phase_n = phase_inc;
                    if (hit) begin
                        miss_n  = '0;
                        frame_n = last;
                    end else begin
                        err_n  = 1'b1;
                        miss_n = miss + 2'd1;
                        state_n = (miss == 2'(MISS_LIMIT - 1)) ? HUNT : LOCK;
                    end
                end
                default: state_n = HUNT;
            endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= HUNT;
            phase       <= '0;
            good        <= '0;
            miss        <= '0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            err_cnt     <= '0;
            frame_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            good        <= good_n;
            miss        <= miss_n;
            locked      <= state_n == LOCK;
            err_pulse   <= err_n;
            err_cnt     <= cnt_n;
            frame_pulse <= frame_n;
        end
endmodule

// File: tb/tb_signal_checker.sv
// tb_signal_checker: directed and random stimulus against a bit-list reference model
module tb_signal_checker;
    logic       clk = 0, rst = 1, en = 0, din = 0, clr = 0;
    logic       locked, err_pulse, frame_pulse;
    logic [7:0] err_cnt;
    logic [2:0] phase;

    signal_checker dut (.clk(clk), .rst(rst), .en(en), .din(din), .clr(clr), .locked(locked),
                        .err_pulse(err_pulse), .err_cnt(err_cnt), .frame_pulse(frame_pulse), .phase(phase));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int P[6] = '{1, 0, 0, 1, 1, 1};
    int m, ph, good, miss, ecnt, ep, fp, s;
    int hq[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m = 0; ph = 0; good = 0; miss = 0; ecnt = 0; ep = 0; fp = 0;
        hq = '{0, 0, 0, 0, 0, 0};
    endtask

    // m: 0 hunting, 1 confirming, 2 locked
    task automatic mstep(int e, int d, int c);
        int ok;
        ep = 0; fp = 0;
        if (e != 0) begin
            hq.push_back(d);
            hq.delete(0);
            if (m == 0) begin
                ok = 1;
                for (int i = 0; i < 6; i++) if (hq[i] != P[i]) ok = 0;
                if (ok != 0) begin m = 1; ph = 0; good = 0; end
            end else if (m == 1) begin
                if (d == P[ph]) begin
                    ph = (ph + 1) % 6;
                    good++;
                    if (good == 6) begin m = 2; miss = 0; end
                end else m = 0;
            end else begin
                if (d == P[ph]) begin
                    miss = 0;
                    fp = (ph == 5);
                end else begin
                    ep = 1;
                    miss++;
                    if (miss == 3) m = 0;
                end
                ph = (ph + 1) % 6;
            end
        end
        if (c != 0) ecnt = 0;
        else if (ep != 0 && ecnt < 255) ecnt++;
    endtask

    task automatic check_all(string tag);
        chk({tag, ".locked"}, locked, m == 2);
        chk({tag, ".err_pulse"}, err_pulse, ep);
        chk({tag, ".frame_pulse"}, frame_pulse, fp);
        chk({tag, ".err_cnt"}, err_cnt, ecnt);
        if (m != 0) chk({tag, ".phase"}, phase, ph);
    endtask

    task automatic tick(int e, int d, int c);
        en = e[0]; din = d[0]; clr = c[0];
        @(posedge clk);
        mstep(e, d, c);
        #1;
        check_all("step");
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        mreset();
        check_all("reset");
        chk("reset.phase", phase, 0);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic send_pat(int n);
        for (int i = 0; i < n; i++) tick(1, P[i % 6], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        for (int i = 1; i <= 18; i++) begin
            tick(1, P[(i - 1) % 6], 0);
            if (i == 11) chk("lock_b11", locked, 0);
            if (i == 12) chk("lock_b12", locked, 1);
            if (i == 17) chk("frame_b17", frame_pulse, 0);
            if (i == 18) chk("frame_b18", frame_pulse, 1);
        end
        for (int i = 19; i <= 30; i++) begin
            tick(1, P[(i - 1) % 6] ^ (i == 20), 0);
            if (i == 20) begin chk("err_b20", err_pulse, 1); chk("cnt_b20", err_cnt, 1); end
            if (i == 21) chk("err_b21", err_pulse, 0);
            if (i == 30) begin chk("frame_b30", frame_pulse, 1); chk("lock_b30", locked, 1); end
        end
        for (int i = 31; i <= 33; i++) tick(1, P[(i - 1) % 6] ^ 1, 0);
        chk("unlock_cnt", err_cnt, 4);
        chk("unlock", locked, 0);
        for (int j = 1; j <= 18; j++) begin
            tick(1, P[(j - 1) % 6], 0);
            if (j == 11) chk("relock_b11", locked, 0);
            if (j == 12) chk("relock_b12", locked, 1);
        end
        // en gaps while locked must freeze everything
        for (int i = 0; i < 4; i++) tick(0, $urandom_range(0, 1), 0);
        chk("gap_lock", locked, 1);

        do_reset();
        send_pat(6);
        tick(1, 1, 0); tick(1, 0, 0); tick(1, 1, 0);
        chk("confirm_fail_lock", locked, 0);
        chk("confirm_fail_cnt", err_cnt, 0);
        send_pat(18);
        chk("confirm_relock", locked, 1);

        for (int k = 0; k < 450; k++) tick(1, P[ph] ^ (k % 3 != 2), 0);
        chk("sat_cnt", err_cnt, 255);
        chk("sat_lock", locked, 1);
        tick(1, P[ph] ^ 1, 1);
        chk("clr_wins", err_cnt, 0);
        tick(1, P[ph] ^ 1, 0);

        #2 rst = 1;
        #1;
        chk("async_locked", locked, 0);
        chk("async_cnt", err_cnt, 0);
        chk("async_err", err_pulse, 0);
        mreset();
        #3 rst = 0;
        tick(1, P[0], 0);
        tick(1, P[1], 0);
        send_pat(18);
        chk("post_rst_lock", locked, 1);

        s = 0;
        for (int k = 0; k < 2000; k++) begin
            int e, d;
            e = ($urandom_range(0, 3) != 0);
            d = (m != 0 ? P[ph] : P[s % 6]) ^ ($urandom_range(0, 19) == 0);
            if (e != 0 && m == 0) s++;
            tick(e, d, $urandom_range(0, 49) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
